// File: rtl/axi_arb_pkg.sv
// Shared constants for the AXI read arbiter: FSM state encoding,
// AXI read response codes and default bus widths.
package axi_arb_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/axi_arb_prio_sel.sv
// Fixed-priority encoder: lowest set request bit wins.
// Ports: req (request vector) -> idx (winner index), any_valid.
module axi_arb_prio_sel
    import axi_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             any_valid
);

    // Scan from the top down so the lowest index is written last.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any_valid = |req;

endmodule

// File: rtl/axi_read_arbiter.sv
// AXI4 read arbiter: NUM_MASTERS requesters onto one read master port,
// one outstanding burst at a time, fixed priority (lowest index wins).
// Ports: clock/reset (sync, active-high); in_ar*/in_r* per-requester
// slots (packed, slot i at [i*W +: W]); io_master_ar*/r* downstream.
// R data/resp/last are shared by all slots; per-slot rvalid selects.
// Optional: define AXI_READ_ARBITER_CHECK_EN for simulation checks.
module axi_read_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_MASTERS-1:0]        in_arvalid,
    output logic [NUM_MASTERS-1:0]        in_arready,
    input  logic [NUM_MASTERS*ADDR_W-1:0] in_araddr,
    input  logic [NUM_MASTERS*8-1:0]      in_arlen,
    output logic [NUM_MASTERS-1:0]        in_rvalid,
    input  logic [NUM_MASTERS-1:0]        in_rready,
    output logic [DATA_W-1:0]             in_rdata,
    output logic [1:0]                    in_rresp,
    output logic                          in_rlast,
    output logic                          io_master_arvalid,
    input  logic                          io_master_arready,
    output logic [ADDR_W-1:0]             io_master_araddr,
    output logic [7:0]                    io_master_arlen,
    input  logic                          io_master_rvalid,
    output logic                          io_master_rready,
    input  logic [DATA_W-1:0]             io_master_rdata,
    input  logic [1:0]                    io_master_rresp,
    input  logic                          io_master_rlast
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [7:0]       beat_cnt_q, beat_cnt_d;
    logic [7:0]       len_q, len_d;

    logic [IDX_W-1:0]  sel_idx;
    logic              sel_any;
    logic [ADDR_W-1:0] gnt_addr;
    logic [7:0]        gnt_len;
    logic              gnt_arvalid;
    logic              ar_hs;
    logic              r_hs;

    axi_arb_prio_sel #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_prio_sel (
        .req       (in_arvalid),
        .idx       (sel_idx),
        .any_valid (sel_any)
    );

    // Address/length of the granted slot; the requester holds them.
    assign gnt_addr    = in_araddr[int'(grant_q)*ADDR_W +: ADDR_W];
    assign gnt_len     = in_arlen[int'(grant_q)*8 +: 8];
    assign gnt_arvalid = in_arvalid[grant_q];

    assign io_master_araddr = gnt_addr;
    assign io_master_arlen  = gnt_len;

    // Pure pass-through on the R payload.
    assign in_rdata = io_master_rdata;
    assign in_rresp = io_master_rresp;
    assign in_rlast = io_master_rlast;

    assign ar_hs = io_master_arvalid && io_master_arready;
    assign r_hs  = io_master_rvalid && io_master_rready;

    always_comb begin
        state_d           = state_q;
        grant_d           = grant_q;
        beat_cnt_d        = beat_cnt_q;
        len_d             = len_q;
        in_arready        = '0;
        in_rvalid         = '0;
        io_master_arvalid = 1'b0;
        io_master_rready  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sel_any) begin
                    grant_d = sel_idx;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                io_master_arvalid   = gnt_arvalid;
                in_arready[grant_q] = io_master_arready;
                if (ar_hs) begin
                    len_d      = gnt_len;
                    beat_cnt_d = '0;
                    state_d    = DATA;
                end else if (!gnt_arvalid) begin
                    // Requester withdrew; re-arbitrate.
                    state_d = IDLE;
                end
            end
            DATA: begin
                in_rvalid[grant_q] = io_master_rvalid;
                io_master_rready   = in_rready[grant_q];
                if (r_hs) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (io_master_rlast) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            beat_cnt_q <= '0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
        end
    end

`ifdef AXI_READ_ARBITER_CHECK_EN
    logic [ADDR_W-1:0] chk_addr_q;
    logic [7:0]        chk_len_q;
    logic              chk_was_addr_q;

    always_ff @(posedge clock) begin
        chk_addr_q <= gnt_addr;
        chk_len_q  <= gnt_len;
        if (reset) begin
            chk_was_addr_q <= 1'b0;
        end else begin
            chk_was_addr_q <= (state_q == ADDR);
            if (state_q == DATA && io_master_rvalid &&
                (io_master_rlast != (beat_cnt_q == len_q))) begin
                $error("axi_read_arbiter: rlast at beat %0d, len %0d",
                       beat_cnt_q, len_q);
            end
            if (state_q != DATA && io_master_rvalid) begin
                $error("axi_read_arbiter: rvalid outside DATA");
            end
            if (state_q == ADDR && !gnt_arvalid) begin
                $error("axi_read_arbiter: arvalid dropped in ADDR");
            end
            // Grant cannot change while ADDR persists, so compare slots.
            if (state_q == ADDR && chk_was_addr_q &&
                (gnt_addr != chk_addr_q || gnt_len != chk_len_q)) begin
                $error("axi_read_arbiter: araddr/arlen changed in ADDR");
            end
        end
    end
`endif

endmodule
